// File: rtl/result_collector.sv
// rtl/result_collector.sv - per-EU result slots arbitrated round-robin onto one register-file write port
module result_collector #(
    parameter int NumEus      = 2,
    parameter int NumTags     = 8,
    parameter int RegIdxWidth = 6,
    parameter int WarpWidth   = 32,
    parameter int RegWidth    = 32,
    localparam int TagWidth   = $clog2(NumTags)
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [NumEus-1:0]                               eu_valid_i,
    output logic [NumEus-1:0]                               eu_ready_o,
    input  logic [NumEus-1:0][TagWidth-1:0]                 eu_tag_i,
    input  logic [NumEus-1:0][RegIdxWidth-1:0]              eu_dst_i,
    input  logic [NumEus-1:0][WarpWidth-1:0]                eu_act_mask_i,
    input  logic [NumEus-1:0][WarpWidth-1:0][RegWidth-1:0]  eu_data_i,
    input  logic                                            rf_ready_i,
    output logic                                            rf_valid_o,
    output logic [RegIdxWidth-1:0]                          rf_dst_o,
    output logic [WarpWidth-1:0]                            rf_act_mask_o,
    output logic [WarpWidth-1:0][RegWidth-1:0]              rf_data_o,
    output logic                                            wb_valid_o,
    output logic [TagWidth-1:0]                             wb_tag_o
);

    localparam int EuIdxW = (NumEus > 1) ? $clog2(NumEus) : 1;

    logic [NumEus-1:0]                               r_full;
    logic [NumEus-1:0][TagWidth-1:0]                 r_tag;
    logic [NumEus-1:0][RegIdxWidth-1:0]              r_dst;
    logic [NumEus-1:0][WarpWidth-1:0]                r_mask;
    logic [NumEus-1:0][WarpWidth-1:0][RegWidth-1:0]  r_data;
    logic [EuIdxW-1:0]                               r_ptr;
    logic                                            r_lock;
    logic [EuIdxW-1:0]                               r_lock_idx;

    logic [EuIdxW-1:0] w_cand;
    logic [EuIdxW-1:0] w_rr_idx;
    logic              w_rr_found;
    logic [EuIdxW-1:0] w_gnt;
    logic [EuIdxW-1:0] w_ptr_next;
    logic              w_rf_valid;
    logic              w_hs;

    // First full slot at or after the priority pointer, wrapping around.
    always_comb begin
        w_cand     = '0;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < NumEus; k++) begin
            w_cand = EuIdxW'((int'(r_ptr) + k) % NumEus);
            if (!w_rr_found && r_full[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // A stalled grant stays put so the register file sees a stable request.
    assign w_gnt      = r_lock ? r_lock_idx : w_rr_idx;
    assign w_rf_valid = |r_full;
    assign w_hs       = w_rf_valid && rf_ready_i;
    assign w_ptr_next = (w_gnt == EuIdxW'(NumEus - 1)) ? '0 : w_gnt + EuIdxW'(1);

    always_comb begin
        eu_ready_o = '0;
        for (int i = 0; i < NumEus; i++) begin
            eu_ready_o[i] = !r_full[i] || (w_hs && (w_gnt == EuIdxW'(i)));
        end
    end

    assign rf_valid_o    = w_rf_valid;
    assign rf_dst_o      = w_rf_valid ? r_dst[w_gnt]  : '0;
    assign rf_act_mask_o = w_rf_valid ? r_mask[w_gnt] : '0;
    assign rf_data_o     = w_rf_valid ? r_data[w_gnt] : '0;
    assign wb_valid_o    = w_hs;
    assign wb_tag_o      = w_rf_valid ? r_tag[w_gnt]  : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full     <= '0;
            r_tag      <= '0;
            r_dst      <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            for (int i = 0; i < NumEus; i++) begin
                if (eu_valid_i[i] && eu_ready_o[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= eu_tag_i[i];
                    r_dst[i]  <= eu_dst_i[i];
                    r_mask[i] <= eu_act_mask_i[i];
                    r_data[i] <= eu_data_i[i];
                end else if (w_hs && (w_gnt == EuIdxW'(i))) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_hs) begin
                r_ptr <= w_ptr_next;
            end
            r_lock     <= w_rf_valid && !rf_ready_i;
            r_lock_idx <= w_gnt;
        end
    end

`ifndef SYNTHESIS
    for (genvar g = 0; g < NumEus; g++) begin : g_chk_eu
        a_eu_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (eu_valid_i[g] && !eu_ready_o[g]) |=>
            (eu_valid_i[g] && $stable(eu_tag_i[g]) && $stable(eu_dst_i[g]) &&
             $stable(eu_act_mask_i[g]) && $stable(eu_data_i[g])))
            else $error("eu %0d dropped or changed a result while not ready", g);
        for (genvar h = g + 1; h < NumEus; h++) begin : g_chk_tag
            a_tag_unique: assert property (@(posedge clk_i) disable iff (rst_i)
                !(r_full[g] && r_full[h] && (r_tag[g] == r_tag[h])))
                else $error("slots %0d and %0d hold the same tag", g, h);
        end
    end
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - scoreboard bench for result_collector
module tb_result_collector;

    typedef struct {
        logic [2:0]        tag;
        logic [5:0]        dst;
        logic [31:0]       mask;
        logic [31:0][31:0] data;
    } res_t;

    logic                   clk;
    logic                   rst;
    logic [1:0]             eu_valid_i;
    logic [1:0]             eu_ready_o;
    logic [1:0][2:0]        eu_tag_i;
    logic [1:0][5:0]        eu_dst_i;
    logic [1:0][31:0]       eu_act_mask_i;
    logic [1:0][31:0][31:0] eu_data_i;
    logic                   rf_ready_i;
    logic                   rf_valid_o;
    logic [5:0]             rf_dst_o;
    logic [31:0]            rf_act_mask_o;
    logic [31:0][31:0]      rf_data_o;
    logic                   wb_valid_o;
    logic [2:0]             wb_tag_o;

    res_t sb[$];
    logic [1:0] acc;
    int n_checks = 0;
    int n_pass   = 0;

    result_collector dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .eu_valid_i   (eu_valid_i),
        .eu_ready_o   (eu_ready_o),
        .eu_tag_i     (eu_tag_i),
        .eu_dst_i     (eu_dst_i),
        .eu_act_mask_i(eu_act_mask_i),
        .eu_data_i    (eu_data_i),
        .rf_ready_i   (rf_ready_i),
        .rf_valid_o   (rf_valid_o),
        .rf_dst_o     (rf_dst_o),
        .rf_act_mask_o(rf_act_mask_o),
        .rf_data_o    (rf_data_o),
        .wb_valid_o   (wb_valid_o),
        .wb_tag_o     (wb_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic make_item(input int tag, input int dst, input logic [31:0] mask, output res_t r);
        r.tag  = tag[2:0];
        r.dst  = dst[5:0];
        r.mask = mask;
        for (int w = 0; w < 32; w++) r.data[w] = $urandom;
    endtask

    task automatic drive_eu(input int i, input res_t r);
        eu_valid_i[i]    = 1'b1;
        eu_tag_i[i]      = r.tag;
        eu_dst_i[i]      = r.dst;
        eu_act_mask_i[i] = r.mask;
        eu_data_i[i]     = r.data;
    endtask

    // Called #1 after a negedge: records EU acceptance, checks any completion
    // against the scoreboard, then advances to the next negedge.
    task automatic tick();
        res_t e;
        for (int i = 0; i < 2; i++) acc[i] = eu_valid_i[i] && eu_ready_o[i];
        if (wb_valid_o) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_completion: got wb_tag=%0d, required no completion", wb_tag_o);
            end else begin
                e = sb.pop_front();
                if (wb_tag_o !== e.tag || rf_dst_o !== e.dst || rf_act_mask_o !== e.mask || rf_data_o !== e.data)
                    $display("FAIL completion: got tag=%0d dst=%0d mask=%h d0=%h, required tag=%0d dst=%0d mask=%h d0=%h",
                             wb_tag_o, rf_dst_o, rf_act_mask_o, rf_data_o[0], e.tag, e.dst, e.mask, e.data[0]);
                else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (eu_ready_o !== 2'b11) $display("FAIL reset_eu_ready: got %b, required 11", eu_ready_o); else n_pass++;
        n_checks++; if (rf_valid_o !== 1'b0) $display("FAIL reset_rf_valid: got %b, required 0", rf_valid_o); else n_pass++;
        n_checks++; if (wb_valid_o !== 1'b0) $display("FAIL reset_wb_valid: got %b, required 0", wb_valid_o); else n_pass++;
        n_checks++; if (rf_dst_o !== 6'd0 || wb_tag_o !== 3'd0) $display("FAIL reset_dst_tag: got dst=%0d tag=%0d, required 0 0", rf_dst_o, wb_tag_o); else n_pass++;
        n_checks++; if (rf_act_mask_o !== 32'd0 || rf_data_o !== '0) $display("FAIL reset_mask_data: got mask=%h d0=%h, required zero", rf_act_mask_o, rf_data_o[0]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        res_t a;
        rf_ready_i = 1'b1;
        make_item(3, 5, 32'hFFFF_FFFF, a);
        drive_eu(0, a);
        sb.push_back(a);
        #1;
        n_checks++; if (rf_valid_o !== 1'b0) $display("FAIL single_no_comb_path: got rf_valid=%b, required 0", rf_valid_o); else n_pass++;
        tick();
        eu_valid_i[0] = 1'b0;
        #1;
        n_checks++; if (rf_valid_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_tag_o !== 3'd3)
            $display("FAIL single_n_plus_1: got rf_valid=%b wb_valid=%b tag=%0d, required 1 1 3", rf_valid_o, wb_valid_o, wb_tag_o); else n_pass++;
        tick();
        #1;
        n_checks++; if (rf_valid_o !== 1'b0 || wb_valid_o !== 1'b0)
            $display("FAIL single_n_plus_2: got rf_valid=%b wb_valid=%b, required 0 0", rf_valid_o, wb_valid_o); else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        res_t a, b;
        do_reset();
        rf_ready_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            make_item(1, 10 + r, 32'h1234_5678, a);
            make_item(2, 20 + r, 32'h0F0F_0F0F, b);
            drive_eu(0, a);
            drive_eu(1, b);
            sb.push_back(a);
            sb.push_back(b);
            #1; tick();
            eu_valid_i = 2'b00;
            #1;
            n_checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 3'd1)
                $display("FAIL contention_first round%0d: got wb_valid=%b tag=%0d, required 1 1", r, wb_valid_o, wb_tag_o); else n_pass++;
            tick();
            #1;
            n_checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 3'd2)
                $display("FAIL contention_second round%0d: got wb_valid=%b tag=%0d, required 1 2", r, wb_valid_o, wb_tag_o); else n_pass++;
            tick();
            #1;
            n_checks++; if (rf_valid_o !== 1'b0) $display("FAIL contention_idle round%0d: got rf_valid=%b, required 0", r, rf_valid_o); else n_pass++;
            tick();
        end
    endtask

    task automatic test_fairness();
        res_t f0[6];
        res_t f1[6];
        int idx0, idx1, g0, g1, ncomp;
        for (int k = 0; k < 6; k++) begin
            make_item((2 * k) % 8, k, 32'hA5A5_0000 | k, f0[k]);
            make_item((2 * k + 1) % 8, 32 + k, 32'h5A5A_0000 | k, f1[k]);
            sb.push_back(f0[k]);
            sb.push_back(f1[k]);
        end
        idx0 = 0; idx1 = 0; g0 = 0; g1 = 0; ncomp = 0;
        rf_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            if (idx0 < 6) drive_eu(0, f0[idx0]); else eu_valid_i[0] = 1'b0;
            if (idx1 < 6) drive_eu(1, f1[idx1]); else eu_valid_i[1] = 1'b0;
            #1;
            if (wb_valid_o && ncomp < 10) begin
                if (wb_tag_o[0]) g1++; else g0++;
                ncomp++;
            end
            tick();
            if (acc[0]) idx0++;
            if (acc[1]) idx1++;
        end
        eu_valid_i = 2'b00;
        n_checks++; if (sb.size() != 0) $display("FAIL fairness_drained: got %0d pending, required 0", sb.size()); else n_pass++;
        n_checks++; if (g0 != 5 || g1 != 5) $display("FAIL fairness_share: got eu0=%0d eu1=%0d, required 5 5", g0, g1); else n_pass++;
    endtask

    task automatic test_backpressure();
        res_t w, x, y;
        rf_ready_i = 1'b1;
        make_item(0, 1, 32'hFFFF_0000, w);
        drive_eu(0, w);
        sb.push_back(w);
        #1; tick();
        eu_valid_i[0] = 1'b0;
        #1; tick();
        rf_ready_i = 1'b0;
        make_item(1, 7, 32'h0000_0000, x);
        make_item(2, 9, 32'h8000_0001, y);
        drive_eu(0, x);
        sb.push_back(x);
        sb.push_back(y);
        #1; tick();
        eu_valid_i[0] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s == 0) drive_eu(1, y); else eu_valid_i[1] = 1'b0;
            #1;
            n_checks++; if (rf_valid_o !== 1'b1 || rf_dst_o !== x.dst || rf_act_mask_o !== x.mask || rf_data_o !== x.data)
                $display("FAIL backpressure_hold s%0d: got valid=%b dst=%0d mask=%h, required 1 %0d %h", s, rf_valid_o, rf_dst_o, rf_act_mask_o, x.dst, x.mask); else n_pass++;
            n_checks++; if (wb_valid_o !== 1'b0 || eu_ready_o[0] !== 1'b0)
                $display("FAIL backpressure_stall s%0d: got wb_valid=%b eu_ready0=%b, required 0 0", s, wb_valid_o, eu_ready_o[0]); else n_pass++;
            tick();
        end
        rf_ready_i = 1'b1;
        #1;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 3'd1)
            $display("FAIL backpressure_release: got wb_valid=%b tag=%0d, required 1 1", wb_valid_o, wb_tag_o); else n_pass++;
        tick();
        #1; tick();
        n_checks++; if (sb.size() != 0) $display("FAIL backpressure_drained: got %0d pending, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_drain_refill();
        res_t p, q;
        rf_ready_i = 1'b1;
        make_item(5, 3, 32'hDEAD_BEEF, p);
        make_item(6, 4, 32'h0000_FFFF, q);
        drive_eu(0, p);
        sb.push_back(p);
        #1; tick();
        drive_eu(0, q);
        sb.push_back(q);
        #1;
        n_checks++; if (eu_ready_o[0] !== 1'b1) $display("FAIL refill_ready: got eu_ready0=%b, required 1", eu_ready_o[0]); else n_pass++;
        tick();
        eu_valid_i[0] = 1'b0;
        #1;
        n_checks++; if (rf_valid_o !== 1'b1 || wb_tag_o !== 3'd6 || rf_dst_o !== 6'd4)
            $display("FAIL refill_contents: got valid=%b tag=%0d dst=%0d, required 1 6 4", rf_valid_o, wb_tag_o, rf_dst_o); else n_pass++;
        tick();
        #1;
        n_checks++; if (rf_valid_o !== 1'b0) $display("FAIL refill_empty: got rf_valid=%b, required 0", rf_valid_o); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        res_t a, b;
        rf_ready_i = 1'b0;
        make_item(3, 11, 32'hCAFE_0001, a);
        make_item(4, 12, 32'hCAFE_0002, b);
        drive_eu(0, a);
        drive_eu(1, b);
        #1; tick();
        eu_valid_i = 2'b00;
        #1;
        n_checks++; if (rf_valid_o !== 1'b1 || eu_ready_o !== 2'b00)
            $display("FAIL reset_mid_setup: got rf_valid=%b eu_ready=%b, required 1 00", rf_valid_o, eu_ready_o); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (rf_valid_o !== 1'b0 || eu_ready_o !== 2'b11 || wb_valid_o !== 1'b0 || rf_dst_o !== 6'd0)
            $display("FAIL reset_mid_async: got rf_valid=%b eu_ready=%b wb_valid=%b dst=%0d, required 0 11 0 0", rf_valid_o, eu_ready_o, wb_valid_o, rf_dst_o); else n_pass++;
        tick();
        rst = 1'b0;
        rf_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (wb_valid_o !== 1'b0 || rf_valid_o !== 1'b0)
                $display("FAIL reset_mid_discard c%0d: got wb_valid=%b rf_valid=%b, required 0 0", c, wb_valid_o, rf_valid_o); else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst           = 1'b1;
        eu_valid_i    = '0;
        eu_tag_i      = '0;
        eu_dst_i      = '0;
        eu_act_mask_i = '0;
        eu_data_i     = '0;
        rf_ready_i    = 1'b0;
        acc           = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_drain_refill();
        test_reset_mid();
        n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NumEus, default 2: number of execution units returning results.
REQ-002 SHALL have parameter NumTags, default 8: inflight tags; TagWidth = $clog2(NumTags), dependent, not overridden.
REQ-003 SHALL have parameter RegIdxWidth, default 6: destination register index width.
REQ-004 SHALL have parameter WarpWidth, default 32: threads per warp, active-mask width.
REQ-005 SHALL have parameter RegWidth, default 32: data bits per thread.
REQ-006 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port eu_valid_i  input  NumEus  per-EU result valid.
REQ-009 SHALL have port eu_ready_o  output  NumEus  per-EU result accept.
REQ-010 SHALL have port eu_tag_i  input  NumEus x TagWidth  per-EU instruction tag.
REQ-011 SHALL have port eu_dst_i  input  NumEus x RegIdxWidth  per-EU destination register.
REQ-012 SHALL have port eu_act_mask_i  input  NumEus x WarpWidth  per-EU active mask.
REQ-013 SHALL have port eu_data_i  input  NumEus x WarpWidth x RegWidth  per-EU result data.
REQ-014 SHALL have port rf_ready_i  input  1  register file write accept.
REQ-015 SHALL have ports rf_valid_o (1), rf_dst_o (RegIdxWidth), rf_act_mask_o (WarpWidth), rf_data_o (WarpWidth x RegWidth): outputs, register file write request.
REQ-016 SHALL have ports wb_valid_o (1), wb_tag_o (TagWidth): outputs, completion toward dispatcher (drives its eu_valid_i/eu_tag_i).

Function
REQ-017 SHALL hold one 1-entry slot per EU (full bit, tag, dst, mask, data); slot i captures EU i inputs on eu_valid_i[i] && eu_ready_o[i].
REQ-018 SHALL drive eu_ready_o[i] = !full[i] || (slot i granted && rf_valid_o && rf_ready_i); drain and refill of one slot in the same cycle keeps full[i]=1 with new contents.
REQ-019 SHALL drive rf_valid_o = OR of full bits; rf_dst_o/rf_act_mask_o/rf_data_o from granted slot; data, mask, dst forwarded unmodified, including all-zero masks.
REQ-020 SHALL select grant round-robin: first full slot at or after priority pointer ptr, searching upward modulo NumEus.
REQ-021 SHALL advance ptr to (granted index + 1) mod NumEus on each rf handshake; ptr unchanged otherwise.
REQ-022 SHALL lock the grant while rf_valid_o && !rf_ready_i; granted slot and all rf_* outputs stay stable until handshake, even if higher-priority slots fill.
REQ-023 SHALL assert wb_valid_o = rf_valid_o && rf_ready_i, with wb_tag_o = granted slot tag, same cycle; exactly one completion per accepted result.
REQ-024 SHALL have latency: EU handshake in cycle N -> rf_valid_o earliest in cycle N+1; no combinational path eu_*_i -> rf_*_o/wb_*_o.
REQ-025 SHALL sustain one result per cycle when rf_ready_i=1 and any slot is full.
REQ-026 SHALL drive wb_tag_o and rf_* as don't-care (hold zero) when rf_valid_o=0.
REQ-027 SHALL, in simulation only, flag an error when two full slots carry the same tag, or when eu_valid_i[i] drops or its payload changes while eu_ready_o[i]=0.

Reset
REQ-028 SHALL, on rst_i=1, asynchronously clear all full bits, set ptr=0, release grant lock, zero slot payloads.
REQ-029 SHALL drive during/after reset: eu_ready_o=all ones, rf_valid_o=0, wb_valid_o=0, rf_dst_o=0, rf_act_mask_o=0, rf_data_o=0, wb_tag_o=0.
REQ-030 SHALL discard results held at reset mid-operation; no completion issued for them.

Verification
REQ-031 SHALL cover single result: EU0 tag=3 dst=5 mask=0xFFFF_FFFF at cycle N, rf_ready_i=1 -> rf_valid_o, wb_valid_o, wb_tag_o=3 in N+1 only.
REQ-032 SHALL cover contention: EU0 tag=1, EU1 tag=2 same cycle, ptr=0 -> completions tag 1 then tag 2 on consecutive cycles; ptr=0 again after.
REQ-033 SHALL cover fairness: both EUs valid every cycle, rf_ready_i=1 for 10 cycles -> grants alternate 0,1,0,1...; each EU gets 5.
REQ-034 SHALL cover backpressure: rf_ready_i=0 for 4 cycles with EU0 slot full, EU1 filling -> outputs stable on EU0, eu_ready_o[0]=0, no wb_valid_o; release -> EU0 first.
REQ-035 SHALL cover drain/refill: EU0 slot full, granted, rf_ready_i=1, eu_valid_i[0]=1 tag=6 -> eu_ready_o[0]=1, next cycle slot 0 holds tag 6.
REQ-036 SHALL cover reset mid-operation: both slots full, rst_i pulsed -> rf_valid_o=0 immediately, eu_ready_o=2'b11, no completion for held tags.
